// File: rtl/register_file_param.sv
//------------------------------------------------------------------------------
// Module      : register_file_param
// Description : Parametrised 2R/1W register file with optional zero register,
//               optional write-to-read bypass and a one-entry-per-cycle sweep clear.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_file_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done
);

    localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_ptr_nxt;
    logic            r_done;
    logic            w_done_nxt;

    logic [WIDTH-1:0] w_mem [DEPTH];
    logic             w_wa_in_range;
    logic             w_wa_zero;
    logic             w_wr_ok;
    logic             w_clearing;

    assign w_clearing    = (r_state == S_CLEAR);
    assign w_wa_in_range = ({1'b0, wa3} < c_depth);
    assign w_wa_zero     = (ZERO_REG != 0) && (wa3 == '0);
    // Gating with rst keeps the bypass path from leaking wd3 while in reset.
    assign w_wr_ok       = rst && !w_clearing && we3 && w_wa_in_range && !w_wa_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (r_ptr == c_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign w_mem[gi] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= '0;
                end else if (w_clearing && (r_ptr == AW'(gi))) begin
                    r_q <= '0;
                end else if (w_wr_ok && (wa3 == AW'(gi))) begin
                    r_q <= wd3;
                end
            end
            assign w_mem[gi] = r_q;
        end
    end

    assign rd1 = ((BYPASS != 0) && w_wr_ok && (wa3 == ra1)) ? wd3 :
                 (({1'b0, ra1} < c_depth) ? w_mem[ra1] : '0);
    assign rd2 = ((BYPASS != 0) && w_wr_ok && (wa3 == ra2)) ? wd3 :
                 (({1'b0, ra2} < c_depth) ? w_mem[ra2] : '0);

    assign clr_busy = w_clearing;
    assign clr_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_register_file_param.sv
//------------------------------------------------------------------------------
// Module      : tb_register_file_param
// Description : Self-checking bench driving four configurations of the register
//               file in parallel against a behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_file_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic       clr_req;

    logic [7:0] w_rd1 [4];
    logic [7:0] w_rd2 [4];
    logic       w_busy [4];
    logic       w_done [4];

    // cfg0 defaults, cfg1 bypass, cfg2 zero register, cfg3 six entries
    int c_depth [4] = '{8, 8, 8, 6};
    int c_zero  [4] = '{0, 0, 1, 0};
    int c_byp   [4] = '{0, 1, 0, 0};

    logic [7:0] m_mem  [4][8];
    bit         m_busy [4];
    bit         m_done [4];
    int         m_left [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    register_file_param #(.WIDTH(8), .DEPTH(8)) u_cfg0 (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .rd1(w_rd1[0]), .rd2(w_rd2[0]), .clr_req(clr_req), .clr_busy(w_busy[0]), .clr_done(w_done[0]));
    register_file_param #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) u_cfg1 (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .rd1(w_rd1[1]), .rd2(w_rd2[1]), .clr_req(clr_req), .clr_busy(w_busy[1]), .clr_done(w_done[1]));
    register_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) u_cfg2 (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .rd1(w_rd1[2]), .rd2(w_rd2[2]), .clr_req(clr_req), .clr_busy(w_busy[2]), .clr_done(w_done[2]));
    register_file_param #(.WIDTH(8), .DEPTH(6)) u_cfg3 (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .rd1(w_rd1[3]), .rd2(w_rd2[3]), .clr_req(clr_req), .clr_busy(w_busy[3]), .clr_done(w_done[3]));

    function automatic bit accepts(int c);
        return rst && !m_busy[c] && we3 && (int'(wa3) < c_depth[c]) &&
               !((c_zero[c] != 0) && (wa3 == 3'd0));
    endfunction

    function automatic logic [7:0] exp_rd(int c, logic [2:0] ra);
        if (!rst || int'(ra) >= c_depth[c] || ((c_zero[c] != 0) && ra == 3'd0))
            return 8'h00;
        if ((c_byp[c] != 0) && accepts(c) && wa3 == ra)
            return wd3;
        return m_mem[c][ra];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 8; i++) m_mem[c][i] = 8'h00;
            m_busy[c] = 1'b0;
            m_done[c] = 1'b0;
            m_left[c] = 0;
        end
    endtask

    // The sweep is modelled as a count of entries still to clear.
    task automatic model_step();
        for (int c = 0; c < 4; c++) begin
            bit acc;
            acc = accepts(c);
            if (m_busy[c]) begin
                m_mem[c][c_depth[c] - m_left[c]] = 8'h00;
                m_left[c]--;
                m_done[c] = (m_left[c] == 0);
                m_busy[c] = (m_left[c] != 0);
            end else begin
                m_done[c] = 1'b0;
                if (acc) m_mem[c][wa3] = wd3;
                if (clr_req) begin
                    m_busy[c] = 1'b1;
                    m_left[c] = c_depth[c];
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write(logic [2:0] a, logic [7:0] d);
        we3 = 1'b1; wa3 = a; wd3 = d;
        cycle();
        we3 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; we3 = 1'b1; wa3 = 3'd1; wd3 = 8'hFF;
        ra1 = 3'd1; ra2 = 3'd1; clr_req = 1'b0;
        model_reset();
        #2;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (w_rd1[c] !== 8'h00 || w_rd2[c] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_rd cfg%0d: rd1=%h rd2=%h want 00", c, w_rd1[c], w_rd2[c]);
            end
            n_tests++;
            if (w_busy[c] !== 1'b0 || w_done[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags cfg%0d: busy=%b done=%b want 0 0", c, w_busy[c], w_done[c]);
            end
        end
        we3 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        cycle();
    endtask

    task automatic test_write_read();
        write(3'd3, 8'h63);
        write(3'd2, 8'h63);
        write(3'd1, 8'h77);
        ra1 = 3'd2; ra2 = 3'd1;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (w_rd1[c] !== 8'h63 || w_rd2[c] !== 8'h77) begin
                n_fail++;
                $display("FAIL write_read cfg%0d: rd1=%h rd2=%h want 63 77", c, w_rd1[c], w_rd2[c]);
            end
        end
        #1 rst = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (w_rd1[c] !== 8'h00 || w_rd2[c] !== 8'h00) begin
                n_fail++;
                $display("FAIL async_reset cfg%0d: rd1=%h rd2=%h want 00", c, w_rd1[c], w_rd2[c]);
            end
        end
        #1 rst = 1'b1;
        cycle();
    endtask

    task automatic test_bypass();
        write(3'd5, 8'h3C);
        we3 = 1'b1; wa3 = 3'd5; wd3 = 8'hA5; ra1 = 3'd5;
        #1;
        n_tests++;
        if (w_rd1[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL no_bypass_pre: rd1=%h want 3c", w_rd1[0]);
        end
        n_tests++;
        if (w_rd1[1] !== 8'hA5) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: rd1=%h want a5", w_rd1[1]);
        end
        cycle();
        we3 = 1'b0;
        #1;
        n_tests++;
        if (w_rd1[0] !== 8'hA5 || w_rd1[1] !== 8'hA5) begin
            n_fail++;
            $display("FAIL bypass_post: cfg0=%h cfg1=%h want a5", w_rd1[0], w_rd1[1]);
        end
    endtask

    task automatic test_zero_reg();
        write(3'd0, 8'hFF);
        write(3'd1, 8'h5A);
        ra1 = 3'd0; ra2 = 3'd1;
        #1;
        n_tests++;
        if (w_rd1[2] !== 8'h00 || w_rd2[2] !== 8'h5A) begin
            n_fail++;
            $display("FAIL zero_reg: rd1=%h rd2=%h want 00 5a", w_rd1[2], w_rd2[2]);
        end
        n_tests++;
        if (w_rd1[0] !== 8'hFF) begin
            n_fail++;
            $display("FAIL reg0_normal: rd1=%h want ff", w_rd1[0]);
        end
    endtask

    task automatic test_nonpow2();
        write(3'd6, 8'h99);
        write(3'd7, 8'h99);
        ra1 = 3'd7; ra2 = 3'd6;
        #1;
        n_tests++;
        if (w_rd1[3] !== 8'h00 || w_rd2[3] !== 8'h00) begin
            n_fail++;
            $display("FAIL out_of_range: rd1=%h rd2=%h want 00", w_rd1[3], w_rd2[3]);
        end
        n_tests++;
        if (w_rd1[0] !== 8'h99 || w_rd2[0] !== 8'h99) begin
            n_fail++;
            $display("FAIL in_range_67: rd1=%h rd2=%h want 99", w_rd1[0], w_rd2[0]);
        end
    endtask

    task automatic test_sweep();
        int cnt_busy [4];
        int cnt_done [4];
        for (int i = 0; i < 8; i++) write(3'(i), 8'(8'h11 * (i + 1)));
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int c = 0; c < 4; c++) begin cnt_busy[c] = 0; cnt_done[c] = 0; end
        for (int j = 0; j < 12; j++) begin
            clr_req = (j == 2);
            we3 = (j >= 2 && j <= 5); wa3 = 3'd7; wd3 = 8'hEE;
            for (int a = 0; a < 4; a++) begin
                ra1 = 3'(a); ra2 = 3'(a + 4);
                #1;
                for (int c = 0; c < 4; c++) begin
                    n_tests++;
                    if (w_rd1[c] !== exp_rd(c, ra1) || w_rd2[c] !== exp_rd(c, ra2)) begin
                        n_fail++;
                        $display("FAIL sweep_rd cfg%0d j%0d ra%0d/%0d: got %h %h want %h %h", c, j, ra1, ra2,
                                 w_rd1[c], w_rd2[c], exp_rd(c, ra1), exp_rd(c, ra2));
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                n_tests++;
                if (w_busy[c] !== m_busy[c] || w_done[c] !== m_done[c]) begin
                    n_fail++;
                    $display("FAIL sweep_flags cfg%0d j%0d: busy=%b done=%b want %b %b", c, j,
                             w_busy[c], w_done[c], m_busy[c], m_done[c]);
                end
                cnt_busy[c] += (w_busy[c] === 1'b1) ? 1 : 0;
                cnt_done[c] += (w_done[c] === 1'b1) ? 1 : 0;
            end
            cycle();
        end
        clr_req = 1'b0; we3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (cnt_busy[c] != c_depth[c] || cnt_done[c] != 1) begin
                n_fail++;
                $display("FAIL sweep_len cfg%0d: busy_cycles=%0d done_pulses=%0d want %0d 1", c,
                         cnt_busy[c], cnt_done[c], c_depth[c]);
            end
        end
        ra1 = 3'd7;
        #1;
        n_tests++;
        if (w_rd1[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL sweep_drop_write: rd1=%h want 00", w_rd1[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            we3 = 1'($urandom); wa3 = 3'($urandom); wd3 = 8'($urandom);
            ra1 = 3'($urandom); ra2 = 3'($urandom);
            clr_req = ($urandom_range(0, 19) == 0);
            #1;
            for (int c = 0; c < 4; c++) begin
                n_tests++;
                if (w_rd1[c] !== exp_rd(c, ra1) || w_rd2[c] !== exp_rd(c, ra2)) begin
                    n_fail++;
                    $display("FAIL rnd_rd cfg%0d n%0d: got %h %h want %h %h", c, n,
                             w_rd1[c], w_rd2[c], exp_rd(c, ra1), exp_rd(c, ra2));
                end
                n_tests++;
                if (w_busy[c] !== m_busy[c] || w_done[c] !== m_done[c]) begin
                    n_fail++;
                    $display("FAIL rnd_flags cfg%0d n%0d: busy=%b done=%b want %b %b", c, n,
                             w_busy[c], w_done[c], m_busy[c], m_done[c]);
                end
            end
            cycle();
        end
        we3 = 1'b0; clr_req = 1'b0;
        for (int n = 0; n < 10; n++) cycle();
    endtask

    task automatic test_reset_mid_sweep();
        int cnt_busy [4];
        int cnt_done [4];
        write(3'd3, 8'h5A);
        write(3'd4, 8'hC3);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        cycle();
        cycle();
        #2 rst = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (w_busy[c] !== 1'b0 || w_done[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL midsweep_flags cfg%0d: busy=%b done=%b want 0 0", c, w_busy[c], w_done[c]);
            end
        end
        for (int a = 0; a < 4; a++) begin
            ra1 = 3'(a); ra2 = 3'(a + 4);
            #1;
            for (int c = 0; c < 4; c++) begin
                n_tests++;
                if (w_rd1[c] !== 8'h00 || w_rd2[c] !== 8'h00) begin
                    n_fail++;
                    $display("FAIL midsweep_regs cfg%0d ra%0d: got %h %h want 00", c, a, w_rd1[c], w_rd2[c]);
                end
            end
        end
        rst = 1'b1;
        cycle();
        for (int c = 0; c < 4; c++) begin cnt_busy[c] = 0; cnt_done[c] = 0; end
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 4; c++) cnt_done[c] += (w_done[c] !== 1'b0) ? 1 : 0;
            cycle();
        end
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (cnt_done[c] != 0) begin
                n_fail++;
                $display("FAIL midsweep_no_done cfg%0d: done_pulses=%0d want 0", c, cnt_done[c]);
            end
            cnt_done[c] = 0;
        end
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 4; c++) begin
                cnt_busy[c] += (w_busy[c] === 1'b1) ? 1 : 0;
                cnt_done[c] += (w_done[c] === 1'b1) ? 1 : 0;
            end
            cycle();
        end
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (cnt_busy[c] != c_depth[c] || cnt_done[c] != 1) begin
                n_fail++;
                $display("FAIL resweep_len cfg%0d: busy_cycles=%0d done_pulses=%0d want %0d 1", c,
                         cnt_busy[c], cnt_done[c], c_depth[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_nonpow2();
        test_sweep();
        test_random();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the 8x8 two-read/one-write register file.
- Width and depth are generic, with an optional hardwired-zero register 0 and an optional write-to-read bypass.
- Adds a multi-cycle "sweep clear" engine that zeroes the array one entry per cycle without asserting reset.
- Sits in the datapath as the general-purpose register bank feeding the ALU operand buses.

Parameters:
- WIDTH, 8: data width of each register, rd1/rd2 and wd3.
- DEPTH, 8: number of registers; need not be a power of two (must be >= 2).
- AW, $clog2(DEPTH): address width of wa3/ra1/ra2.
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes (including sweep).
- BYPASS, 0: 1 = a same-cycle write to the addressed register is forwarded to the read port.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- we3  in  1  write enable
- wa3  in  AW  write address
- wd3  in  WIDTH  write data
- ra1  in  AW  read address, port 1
- ra2  in  AW  read address, port 2
- rd1  out  WIDTH  read data, port 1 (combinational)
- rd2  out  WIDTH  read data, port 2 (combinational)
- clr_req  in  1  start sweep clear (sampled on rising edge)
- clr_busy  out  1  sweep clear in progress
- clr_done  out  1  one-cycle pulse on sweep completion

Behaviour:
- Reset (rst=0, async):
  - All DEPTH registers go to 0; state goes to IDLE; sweep pointer goes to 0.
  - clr_busy=0 and clr_done=0.
  - rd1/rd2 read 0 immediately, without waiting for a clock edge.
  - Reset applies at any time, including mid-sweep; the sweep is aborted and the engine returns to IDLE.
- Write: in IDLE, on a rising edge with we3=1 and wa3<DEPTH, mem[wa3] <= wd3.
  - Writes to wa3>=DEPTH are dropped.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Read: combinational, rdN = mem[raN].
  - raN>=DEPTH returns 0.
  - raN==0 with ZERO_REG=1 returns 0.
  - Both ports may address the same register; both return the same value.
- Bypass:
  - BYPASS=1: if we3=1, the write is accepted (IDLE, in range, not the zero register), and wa3==raN, then rdN=wd3 in the same cycle.
  - BYPASS=0: rdN shows the old value until the edge.
- State machine, IDLE / CLEAR:
  - IDLE -> CLEAR: clr_req=1 at edge k. After edge k, ptr=0 and clr_busy=1. A write presented in the same cycle as clr_req is performed.
  - In CLEAR, each edge does mem[ptr] <= 0.
    - If ptr==DEPTH-1: go to IDLE, clr_busy<=0, clr_done<=1.
    - Otherwise: ptr <= ptr+1.
  - Registers are cleared at edges k+1..k+DEPTH; clr_busy is high for exactly DEPTH cycles; clr_done is high for the one cycle after edge k+DEPTH.
  - In CLEAR, we3 is ignored: writes are dropped and the write side of the bypass is disabled.
  - In CLEAR, reads return current contents, which are partially cleared.
  - clr_req while in CLEAR is ignored.
  - clr_req in the cycle clr_done is high starts a new sweep normally.
- clr_done is 0 in all cycles other than the single completion pulse.
- No other latency: writes are visible on the read ports one edge after issue (zero cycles with BYPASS=1).

Test Plan:
- Reset/write/read (defaults):
  - rst=0 -> rd1=rd2=0.
  - Release reset; write 8'h63 to regs 3 and 2, then 8'h77 to reg 1.
  - ra1=2, ra2=1 -> rd1=8'h63, rd2=8'h77.
  - Drop rst mid-cycle -> rd1=rd2=0 with no clock edge.
- Bypass:
  - BYPASS=0: we3=1, wa3=ra1=5, wd3=8'hA5 -> rd1 stays old value until the edge, then reads 8'hA5.
  - BYPASS=1: same stimulus -> rd1=8'hA5 in the same cycle.
- ZERO_REG=1: write 8'hFF to reg 0 -> rd1 (ra1=0) stays 0; write to reg 1 works normally.
- Sweep clear (DEPTH=8):
  - Fill regs 0..7 with 8'h11..8'h88; pulse clr_req.
  - clr_busy is high for exactly 8 cycles; reg i reads 0 from edge k+1+i onward.
  - clr_done pulses once after edge k+8.
  - we3=1 to reg 7 during the sweep is dropped; reg 7 ends at 0.
  - A second clr_req during the sweep is ignored.
- Non-power-of-two (DEPTH=6, AW=3):
  - Write to wa3=6 and wa3=7 -> dropped; ra1=7 reads 0.
  - Sweep -> clr_busy is high 6 cycles.
- Reset mid-sweep: assert rst=0 three cycles into a sweep -> clr_busy=0, clr_done never pulses, all regs 0.
  - After release, a new clr_req completes in DEPTH cycles.
